// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-port initiator: FSM states, default widths
// and the layout of one buffered CPU request.
package mem_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mem_initiator_cmd_fifo.sv
// Two-entry request buffer. The head is read straight from storage, so an
// entry pushed at one edge becomes visible only after that edge.
module cmd_fifo #(
    parameter int W = 25
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slot[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// CPU-side front end for the slow memory port: buffers two requests, issues
// one at a time while the memory is ready, and returns a one-cycle response.
module mem_initiator #(
    parameter int ADDR_W  = mem_bus_pkg::ADDR_W,
    parameter int DATA_W  = mem_bus_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_q,
    output logic              state_dbg
);

    // Handshake: a request transfers at a rising edge where req_valid and
    // req_ready are both high; responses are single-cycle pulses with no
    // back-pressure, and a strobe is only ever driven while mem_ready is high.

    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(TIMEOUT + 1);

    mem_bus_pkg::state_t state, state_next;

    logic [CW-1:0]     wait_cnt;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              done;
    logic              timed_out;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign req_ready  = !full;
    assign push       = req_valid && req_ready;
    assign head_write = head[EW-1];
    assign head_addr  = head[EW-2 -: ADDR_W];
    assign head_data  = head[DATA_W-1:0];

    // The bus shows the head request whenever one is queued, zero otherwise.
    assign mem_address = empty ? '0 : head_addr;
    assign mem_data    = empty ? '0 : head_data;
    assign state_dbg   = state;

    cmd_fifo #(
        .W (EW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({req_write, req_addr, req_data}),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_comb begin
        state_next = state;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            mem_bus_pkg::IDLE: begin
                if (!empty && mem_ready) begin
                    mem_rden   = !head_write;
                    mem_wren   = head_write;
                    state_next = mem_bus_pkg::WAIT;
                end
            end
            mem_bus_pkg::WAIT: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    pop        = 1'b1;
                    state_next = mem_bus_pkg::IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    // A dead responder costs the request; it is not retried.
                    timed_out  = 1'b1;
                    pop        = 1'b1;
                    state_next = mem_bus_pkg::IDLE;
                end
            end
            default: state_next = mem_bus_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= mem_bus_pkg::IDLE;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_next;
            wait_cnt   <= (state == mem_bus_pkg::WAIT) ? wait_cnt + 1'b1 : '0;
            resp_valid <= done || timed_out;
            if (done || timed_out) begin
                resp_write <= head_write;
                resp_err   <= timed_out;
            end
            if (done && !head_write) begin
                resp_data <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed and randomized checks of mem_initiator against a responder model
// and an in-order reference of expected responses.
module tb_mem_initiator;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [11:0] req_addr;
  logic [11:0] req_data;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_write;
  logic [11:0] resp_data;
  logic        resp_err;
  logic [11:0] mem_address;
  logic [11:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic        mem_ready = 1'b1;
  logic [11:0] mem_q;
  logic        state_dbg;

  int total = 0;
  int bad   = 0;

  // Responder environment
  logic [11:0] rmem [0:127];
  logic [11:0] rd_q = '0;
  logic        init_done = 1'b0;
  int          busy = 0;
  int          cool = 1;
  logic        stuck = 1'b0;

  // Reference model: {write, err, read_data} per accepted request, in order
  logic [13:0] exp_q[$];
  logic [11:0] shadow [0:127];
  logic [11:0] model_last = '0;

  assign mem_q = rd_q;

  mem_initiator dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_write  (resp_write),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_ready   (mem_ready),
    .mem_q       (mem_q),
    .state_dbg   (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) rmem[i] <= '0;
      init_done <= 1'b1;
    end else if (mem_ready && (mem_rden || mem_wren)) begin
      if (mem_wren) rmem[mem_address[6:0]] <= mem_data;
      else rd_q <= rmem[mem_address[6:0]];
      busy <= cool;
      mem_ready <= 1'b0;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1 && !stuck) mem_ready <= 1'b1;
    end else if (!mem_ready && !stuck) begin
      mem_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compares every response pulse against the reference queue.
  always @(negedge clock) begin
    logic [13:0] e;
    logic [11:0] exp_d;
    if (reset_n) begin
      if (mem_rden || mem_wren) chk("strobe_needs_ready", mem_ready, 1);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          exp_d = (e[13] || e[12]) ? model_last : e[11:0];
          chk("resp_write", resp_write, e[13]);
          chk("resp_err", resp_err, e[12]);
          chk("resp_data", resp_data, exp_d);
          model_last = exp_d;
        end
      end
    end
  end

  // Present a request from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic w, input logic [11:0] a, input logic [11:0] d, input logic terr);
    int guard = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      chk("req_ready_wait", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    if (w) begin
      shadow[a[6:0]] = d;
      exp_q.push_back({1'b1, terr, 12'h000});
    end else begin
      exp_q.push_back({1'b0, terr, shadow[a[6:0]]});
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    chk(tag, exp_q.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    int n;
    int strobes;
    int pulses;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    repeat (3) @(negedge clock);

    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_write", resp_write, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_strobes", {mem_rden, mem_wren}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Write then read back, cooldown 1
    cool = 1;
    send(1'b1, 12'o0100, 12'o1234, 1'b0);
    chk("wr_strobe", mem_wren, 1);
    chk("wr_rden_low", mem_rden, 0);
    chk("wr_address", mem_address, 12'o0100);
    chk("wr_data", mem_data, 12'o1234);
    wait_resp(n);
    chk("wr_latency", n, 4);
    chk("wr_resp_write", resp_write, 1);
    @(negedge clock);
    chk("wr_pulse_width", resp_valid, 0);
    send(1'b0, 12'o0100, 12'o0000, 1'b0);
    chk("rd_strobe", mem_rden, 1);
    wait_resp(n);
    chk("rd_latency", n, 4);
    chk("rd_value", resp_data, 12'o1234);
    @(negedge clock);

    // Three back-to-back requests: buffer fills after the second
    send(1'b1, 12'd3, 12'h5a5, 1'b0);
    send(1'b0, 12'd3, 12'h000, 1'b0);
    chk("full_after_two", req_ready, 0);
    send(1'b0, 12'o0100, 12'h000, 1'b0);
    drain("drain_three");

    // Long cooldown
    cool = 4;
    send(1'b1, 12'd4, 12'h321, 1'b0);
    wait_resp(n);
    chk("cool4_latency", n, 7);
    @(negedge clock);

    // Responder never comes back: timeout, then nothing issues while stuck
    cool = 1;
    stuck = 1'b1;
    send(1'b0, 12'd5, 12'h000, 1'b1);
    wait_resp(n);
    chk("timeout_latency", n, 17);
    chk("timeout_err", resp_err, 1);
    @(negedge clock);
    chk("timeout_popped", req_ready, 1);
    send(1'b0, 12'd4, 12'h000, 1'b0);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rden || mem_wren) strobes++;
      @(negedge clock);
    end
    chk("stuck_no_strobe", strobes, 0);
    stuck = 1'b0;
    drain("drain_after_stuck");

    // Reset while a read is in WAIT and another is queued
    cool = 4;
    send(1'b0, 12'd1, 12'h000, 1'b0);
    @(negedge clock);
    chk("pre_reset_wait", state_dbg, 1);
    send(1'b0, 12'd2, 12'h000, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    model_last = '0;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_strobes", {mem_rden, mem_wren}, 0);
    chk("mid_rst_address", mem_address, 0);
    chk("mid_rst_state", state_dbg, 0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (resp_valid) pulses++;
    end
    chk("post_reset_no_resp", pulses, 0);

    // Randomized traffic over a few reused addresses
    for (int i = 0; i < 40; i++) begin
      cool = $urandom_range(1, 4);
      send(1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)), 12'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
